roce_stack_cmd_splitter: RTL



---
 rtl/roce_stack_pkg.sv | 40 ++++
 rtl/roce_stack_chunk_calc.sv | 22 ++
 rtl/roce_stack_cmd_splitter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/roce_stack_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | roce_stack_pkg: DataMover command field layout, split FSM states. Rev 1.0 |
// +--------------------------------------------------------------------------+
package roce_stack_pkg;

  localparam int BTT_LSB  = 0;
  localparam int BTT_MSB  = 22;
  localparam int TYPE_BIT = 23;
  localparam int DSA_LSB  = 24;
  localparam int DSA_MSB  = 29;
  localparam int EOF_BIT  = 30;
  localparam int DRR_BIT  = 31;
  localparam int ADDR_LSB = 32;
  localparam int ADDR_MSB = 95;
  localparam int TAG_LSB  = 96;
  localparam int TAG_MSB  = 103;
  localparam int CMD_W    = 104;

  typedef struct packed {
    logic [7:0]  tag;
    logic [63:0] addr;
    logic        drr;
    logic        eof;
    logic [5:0]  dsa;
    logic        typ;
    logic [22:0] btt;
  } dm_cmd_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/roce_stack_chunk_calc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | roce_stack_chunk_calc: largest chunk of rem not crossing a boundary. 1.0  |
// +--------------------------------------------------------------------------+
module roce_stack_chunk_calc #(
  parameter int BOUNDARY_LOG2 = 12
) (
  input  logic [BOUNDARY_LOG2-1:0] addr_lo,
  input  logic [22:0]              rem,
  output logic [22:0]              chunk,
  output logic                     last
);

  // 2^22 is the largest boundary, which still fits in 23 bits.
  logic [22:0] to_bnd;

  assign to_bnd = (23'd1 << BOUNDARY_LOG2) - 23'(addr_lo);
  assign last   = (rem <= to_bnd);
  assign chunk  = last ? rem : to_bnd;

endmodule
`default_nettype wire

// File: rtl/roce_stack_cmd_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | roce_stack_cmd_splitter: splits DataMover commands at 2^BOUNDARY_LOG2.    |
// | Rev 1.0. Optional stats ports enabled by macro CMD_SPLIT_STATS_EN.        |
// +--------------------------------------------------------------------------+
module roce_stack_cmd_splitter
  import roce_stack_pkg::*;
#(
  parameter int BOUNDARY_LOG2 = 12
) (
  input  logic         clk_i,
  input  logic         aresetn_i,
  input  logic         s_cmd_valid_i,
  output logic         s_cmd_ready_o,
  input  logic [103:0] s_cmd_data_i,
  input  logic         s_err_i,
  output logic         m_cmd_valid_o,
  input  logic         m_cmd_ready_i,
  output logic [103:0] m_cmd_data_o,
  output logic         busy_o
`ifdef CMD_SPLIT_STATS_EN
  ,
  output logic [31:0]  stat_cmds_o,
  output logic [31:0]  stat_chunks_o,
  output logic [31:0]  stat_drops_o
`endif
);

  split_state_e state_q, state_d;
  dm_cmd_t      cmd_in, cmd_out;

  logic [63:0]  addr_q;
  logic [22:0]  rem_q;
  logic         type_q, drr_q, eof_q;
  logic [5:0]   dsa_q;
  logic [3:0]   seq_q;

  logic [22:0]  chunk;
  logic         last;
  logic         load, fire;
  logic         unused_in_tag;

  assign cmd_in        = dm_cmd_t'(s_cmd_data_i);
  assign unused_in_tag = ^cmd_in.tag;

  roce_stack_chunk_calc #(
    .BOUNDARY_LOG2(BOUNDARY_LOG2)
  ) u_chunk_calc (
    .addr_lo(addr_q[BOUNDARY_LOG2-1:0]),
    .rem    (rem_q),
    .chunk  (chunk),
    .last   (last)
  );

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Outputs come from registers only, so a stalled chunk stays stable.
  always_comb begin
    state_d       = state_q;
    s_cmd_ready_o = 1'b0;
    m_cmd_valid_o = 1'b0;
    busy_o        = 1'b0;
    load          = 1'b0;
    fire          = 1'b0;
    cmd_out       = '0;
    case (state_q)
      ST_IDLE: begin
        s_cmd_ready_o = 1'b1;
        if (s_cmd_valid_i && !s_err_i && (cmd_in.btt != '0)) begin
          load    = 1'b1;
          state_d = ST_SPLIT;
        end
      end
      ST_SPLIT: begin
        busy_o        = 1'b1;
        m_cmd_valid_o = 1'b1;
        cmd_out.tag   = {4'b0000, seq_q};
        cmd_out.addr  = addr_q;
        cmd_out.drr   = drr_q;
        cmd_out.eof   = last & eof_q;
        cmd_out.dsa   = dsa_q;
        cmd_out.typ   = type_q;
        cmd_out.btt   = chunk;
        fire          = m_cmd_ready_i;
        if (fire && last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_cmd_data_o = cmd_out;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      addr_q <= '0;
      rem_q  <= '0;
      type_q <= 1'b0;
      dsa_q  <= '0;
      drr_q  <= 1'b0;
      eof_q  <= 1'b0;
      seq_q  <= '0;
    end else if (load) begin
      addr_q <= cmd_in.addr;
      rem_q  <= cmd_in.btt;
      type_q <= cmd_in.typ;
      dsa_q  <= cmd_in.dsa;
      drr_q  <= cmd_in.drr;
      eof_q  <= cmd_in.eof;
    end else if (fire) begin
      addr_q <= addr_q + 64'(chunk);
      rem_q  <= rem_q - chunk;
      seq_q  <= seq_q + 4'd1;
    end
  end

`ifdef CMD_SPLIT_STATS_EN
  logic drop_evt;

  // Error-flagged and zero-length commands are both consumed in IDLE without loading.
  assign drop_evt = (state_q == ST_IDLE) && s_cmd_valid_i && !load;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      stat_cmds_o   <= '0;
      stat_chunks_o <= '0;
      stat_drops_o  <= '0;
    end else begin
      if (load)     stat_cmds_o   <= sat_inc32(stat_cmds_o);
      if (fire)     stat_chunks_o <= sat_inc32(stat_chunks_o);
      if (drop_evt) stat_drops_o  <= sat_inc32(stat_drops_o);
    end
  end
`endif

endmodule
`default_nettype wire
